// File: rtl/universal_shift_register.sv
// Universal shift register: parallel load, LSB- or MSB-first shifting with serial
// input, per-word shift counting with Busy/Done status.
// Optional feature macro: USR_PARITY_EN adds parity_odd input and Parity output.
module universal_shift_register #(
  parameter int unsigned WORD_LENGTH = 8,
  parameter logic [WORD_LENGTH-1:0] RESET_VALUE = '0,
  localparam int unsigned CNT_WIDTH = $clog2(WORD_LENGTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   shift,
  input  logic                   dir,
  input  logic                   Serial_Input,
  input  logic [WORD_LENGTH-1:0] Parallel_Input,
  output logic                   Serial_Output,
  output logic [WORD_LENGTH-1:0] Parallel_Output,
  output logic [CNT_WIDTH-1:0]   Shift_Count,
  output logic                   Busy,
  output logic                   Done
`ifdef USR_PARITY_EN
  ,
  input  logic                   parity_odd,
  output logic                   Parity
`endif
);

  logic [WORD_LENGTH-1:0] data_q, data_d;
  logic                   dir_q, dir_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  // Next-state: load beats shift; counting only advances while a word is in flight
  always_comb begin
    data_d = data_q;
    dir_d  = dir_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (load) begin
      data_d = Parallel_Input;
      dir_d  = dir;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (shift) begin
      if (dir_q) begin
        data_d = {data_q[WORD_LENGTH-2:0], Serial_Input};
      end else begin
        data_d = {Serial_Input, data_q[WORD_LENGTH-1:1]};
      end
      if (busy_q) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(WORD_LENGTH - 1)) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= RESET_VALUE;
      dir_q  <= 1'b0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      dir_q  <= dir_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Outgoing bit is whichever end leaves first in the latched direction
  assign Serial_Output   = dir_q ? data_q[WORD_LENGTH-1] : data_q[0];
  assign Parallel_Output = data_q;
  assign Shift_Count     = cnt_q;
  assign Busy            = busy_q;
  assign Done            = done_q;

`ifdef USR_PARITY_EN
  logic parity_q, parity_d;

  // Parity of the loaded word, optionally inverted for odd parity
  always_comb begin
    parity_d = parity_q;
    if (load) begin
      parity_d = (^Parallel_Input) ^ parity_odd;
    end
  end

  // Parity register, held across shifts
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign Parity = parity_q;
`endif

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (WORD_LENGTH=8) with a
// behavioural reference model and directed plus randomized stimulus.
module tb_universal_shift_register;

  logic       clk;
  logic       reset;
  logic       load;
  logic       shift;
  logic       dir;
  logic       Serial_Input;
  logic [7:0] Parallel_Input;
  logic       Serial_Output;
  logic [7:0] Parallel_Output;
  logic [3:0] Shift_Count;
  logic       Busy;
  logic       Done;
`ifdef USR_PARITY_EN
  logic       parity_odd;
  logic       Parity;
`endif

  universal_shift_register #(.WORD_LENGTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .shift(shift),
    .dir(dir),
    .Serial_Input(Serial_Input),
    .Parallel_Input(Parallel_Input),
    .Serial_Output(Serial_Output),
    .Parallel_Output(Parallel_Output),
    .Shift_Count(Shift_Count),
    .Busy(Busy),
    .Done(Done)
`ifdef USR_PARITY_EN
    ,
    .parity_odd(parity_odd),
    .Parity(Parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int done_seen = 0;

  // Reference model state
  int unsigned m_data;
  bit          m_dir;
  int          m_cnt;
  bit          m_busy;
  bit          m_done;
  bit          m_par;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_data = 0; m_dir = 0; m_cnt = 0; m_busy = 0; m_done = 0; m_par = 0;
    end else if (load) begin
      m_data = Parallel_Input;
      m_dir  = dir;
      m_cnt  = 0;
      m_busy = 1;
      m_done = 0;
`ifdef USR_PARITY_EN
      m_par = (($countones(Parallel_Input) % 2) == 1) ^ parity_odd;
`endif
    end else begin
      m_done = 0;
      if (shift) begin
        if (m_dir) m_data = ((m_data * 2) + Serial_Input) % 256;
        else       m_data = (m_data / 2) + (Serial_Input ? 128 : 0);
        if (m_busy) begin
          m_cnt++;
          if (m_cnt == 8) begin
            m_busy = 0;
            m_done = 1;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    int unsigned exp_sout;
    exp_sout = m_dir ? (m_data / 128) % 2 : m_data % 2;
    chk({tag, "_pout"}, 32'(Parallel_Output), m_data);
    chk({tag, "_sout"}, 32'(Serial_Output), exp_sout);
    chk({tag, "_cnt"},  32'(Shift_Count), 32'(m_cnt));
    chk({tag, "_busy"}, 32'(Busy), 32'(m_busy));
    chk({tag, "_done"}, 32'(Done), 32'(m_done));
`ifdef USR_PARITY_EN
    chk({tag, "_par"}, 32'(Parity), 32'(m_par));
`endif
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
    if (Done === 1'b1) done_seen++;
  endtask

  task automatic drive(input logic r, input logic l, input logic s, input logic d,
                       input logic si, input logic [7:0] pin);
    reset = r; load = l; shift = s; dir = d; Serial_Input = si; Parallel_Input = pin;
  endtask

  logic [7:0] seq;

  initial begin
    drive(1, 1, 1, 0, 0, 8'hFF);
`ifdef USR_PARITY_EN
    parity_odd = 1'b0;
`endif
    m_data = 0; m_dir = 0; m_cnt = 0; m_busy = 0; m_done = 0; m_par = 0;

    // 1: reset dominates load and shift
    cycle("t1");
    cycle("t1");
    chk("t1_pout_const", 32'(Parallel_Output), 32'h00);
    chk("t1_busy_const", 32'(Busy), 32'h0);
    chk("t1_cnt_const",  32'(Shift_Count), 32'h0);

    // 2: right shift of A5, LSB first
    drive(0, 1, 0, 0, 0, 8'hA5);
    cycle("t2ld");
    seq = 8'b1010_0101;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      chk("t2_seq", 32'(Serial_Output), 32'(seq[7-i]));
      chk("t2_nodone", 32'(Done), 32'h0);
      drive(0, 0, 1, 0, 0, 8'h00);
      cycle("t2sh");
    end
    chk("t2_done_after8", 32'(Done), 32'h1);
    chk("t2_pout_final", 32'(Parallel_Output), 32'h00);
    chk("t2_cnt_final", 32'(Shift_Count), 32'd8);
    drive(0, 0, 0, 0, 0, 8'h00);
    cycle("t2idle");
    chk("t2_done_pulse", 32'(Done), 32'h0);
    chk("t2_cnt_hold", 32'(Shift_Count), 32'd8);

    // 3: left shift, serial in 1,1,0,1,0,0,1,0
    drive(0, 1, 0, 1, 0, 8'h00);
    cycle("t3ld");
    seq = 8'b1101_0010;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, 0, seq[7-i], 8'h00);
      cycle("t3sh");
    end
    drive(0, 0, 0, 0, 0, 8'h00);
    cycle("t3idle");
    chk("t3_pout", 32'(Parallel_Output), 32'hD2);
    chk("t3_done_cnt", 32'(done_seen), 32'd1);

    // 4: reload mid-word restarts without Done
    done_seen = 0;
    drive(0, 1, 0, 0, 0, 8'h3C);
    cycle("t4ld");
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 1, 8'h00);
      cycle("t4sh");
    end
    drive(0, 1, 0, 0, 0, 8'hF0);
    cycle("t4rl");
    chk("t4_cnt_restart", 32'(Shift_Count), 32'd0);
    chk("t4_busy_restart", 32'(Busy), 32'h1);
    chk("t4_no_done", 32'(done_seen), 32'd0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, 0, 0, 8'h00);
      cycle("t4sh2");
    end
    drive(0, 0, 0, 0, 0, 8'h00);
    cycle("t4idle");
    chk("t4_one_done", 32'(done_seen), 32'd1);

    // 5: load wins over shift; reset mid-word abandons it
    drive(0, 1, 1, 0, 1, 8'h81);
    cycle("t5ld");
    chk("t5_pout", 32'(Parallel_Output), 32'h81);
    chk("t5_cnt", 32'(Shift_Count), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 0, 1, 8'h00);
      cycle("t5sh");
    end
    drive(1, 0, 1, 0, 1, 8'h00);
    cycle("t5rst");
    drive(0, 0, 0, 0, 0, 8'h00);
    cycle("t5idle");
    chk("t5_pout_rst", 32'(Parallel_Output), 32'h00);
    chk("t5_busy_rst", 32'(Busy), 32'h0);
    chk("t5_no_done", 32'(done_seen), 32'd0);

`ifdef USR_PARITY_EN
    // 6: parity captured on load, held across shifts
    parity_odd = 1'b0;
    drive(0, 1, 0, 0, 0, 8'h07);
    cycle("t6ld1");
    chk("t6_par1", 32'(Parity), 32'h1);
    parity_odd = 1'b1;
    drive(0, 1, 0, 1, 0, 8'h03);
    cycle("t6ld2");
    chk("t6_par2", 32'(Parity), 32'h1);
    parity_odd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0, 1, 8'h00);
      cycle("t6sh");
    end
    chk("t6_par_hold", 32'(Parity), 32'h1);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 2) != 0, 1'($urandom), 1'($urandom), 8'($urandom));
`ifdef USR_PARITY_EN
      parity_odd = 1'($urandom);
`endif
      cycle("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
